// File: rtl/yuv422_conv_arbiter_pkg.sv
// Shared types for the RGB888 -> YUV422 converter arbiter: pixel/beat layouts and FSM states.
package yuv_pkg;

  localparam int PIX_PER_PAIR = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] c;
  } yuv_beat_t;

  typedef enum logic [1:0] {IDLE, PIX0, PIX1} arb_state_t;

endpackage

// File: rtl/yuv422_conv_arbiter_tag_fifo.sv
// Ordering FIFO of requester IDs: one entry per pixel pair currently inside the converter.
module yuv_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: the tag storage is deliberately not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/yuv422_conv_arbiter.sv
// Round-robin sharing of one RGB888->YUV422 converter between NREQ pixel streams, one pixel pair per grant,
// with the converter's output pairs routed back to their owners in grant order.
module yuv422_conv_arbiter
  import yuv_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_valid,
  input  rgb888_t [NREQ-1:0]   i_rgb,
  output logic [NREQ-1:0]      i_ack,
  output logic                 c_valid,
  output rgb888_t              c_rgb,
  input  logic                 c_ack,
  input  logic                 d_valid,
  input  yuv_beat_t            d_yuv,
  output logic                 d_ack,
  output logic [NREQ-1:0]      o_valid,
  output yuv_beat_t            o_yuv,
  input  logic [NREQ-1:0]      o_ack,
  output logic                 o_err
);

  localparam int TW = $clog2(NREQ);

  arb_state_t    state, state_nxt;
  logic [TW-1:0] g, g_nxt;
  logic [TW-1:0] rr, rr_nxt;
  logic [TW-1:0] pick;
  logic          any_valid;

  logic          tag_push, tag_pop, tag_full, tag_empty;
  logic [TW-1:0] tag_head;
  logic          beat_cnt;
  logic          err_set;

  yuv_tag_fifo #(.DEPTH(TAG_DEPTH), .W(TW)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (g),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // Scan downward so the lowest offset from rr (the highest-priority requester) is the last one written.
  always_comb begin
    pick      = rr;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_valid[(int'(rr) + k) % NREQ]) begin
        pick      = TW'((int'(rr) + k) % NREQ);
        any_valid = 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    rr_nxt    = rr;
    tag_push  = 1'b0;
    c_valid   = 1'b0;
    c_rgb     = i_rgb[g];
    i_ack     = '0;
    unique case (state)
      IDLE: begin
        if (any_valid && !tag_full) begin
          g_nxt     = pick;
          state_nxt = PIX0;
        end
      end
      PIX0, PIX1: begin
        c_valid  = i_valid[g];
        i_ack[g] = c_ack;
        if (i_valid[g] && c_ack) begin
          if (state == PIX0) begin
            state_nxt = PIX1;
          end else begin
            tag_push  = 1'b1;
            rr_nxt    = TW'((int'(g) + 1) % NREQ);
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With nothing in flight the converter beat is unrequested: swallow it and flag the error.
  always_comb begin
    o_valid = '0;
    o_yuv   = d_yuv;
    d_ack   = 1'b0;
    tag_pop = 1'b0;
    err_set = 1'b0;
    if (tag_empty) begin
      d_ack   = d_valid;
      err_set = d_valid;
    end else begin
      o_valid[tag_head] = d_valid;
      d_ack             = o_ack[tag_head];
      tag_pop           = d_valid && o_ack[tag_head] && (beat_cnt == 1'(PIX_PER_PAIR - 1));
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      g        <= '0;
      rr       <= '0;
      beat_cnt <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      rr    <= rr_nxt;
      if (d_valid && d_ack && !tag_empty) beat_cnt <= ~beat_cnt;
      if (err_set) o_err <= 1'b1;
    end
  end

endmodule
